// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and the transmit state encoding.
package uart_pkg;

    // Register indices, selected by addr[3:2]
    localparam logic [1:0] IDX_TXDATA = 2'd0;
    localparam logic [1:0] IDX_STATUS = 2'd1;

    // STATUS bit positions
    localparam int unsigned ST_FULL_BIT  = 0;
    localparam int unsigned ST_EMPTY_BIT = 1;
    localparam int unsigned ST_BUSY_BIT  = 2;
    localparam int unsigned ST_OVF_BIT   = 3;

    // Transmit FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and left to the caller
// to flag.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: written on every accepted push
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, STATUS/overflow
// tracking, a TX FIFO and the serialising state machine.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        MemWrite,
    input  logic [31:0] writedata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t state;
    tx_state_t state_nxt;

    logic [1:0]    idx;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;
    logic          overflow;
    logic          busy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [7:0]    shift;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic          baud_done;
    logic          unused;

    assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign idx       = addr[3:2];
    assign push      = sel & MemWrite & (idx == IDX_TXDATA);
    assign ovf_clr   = sel & MemWrite & (idx == IDX_STATUS) & writedata[3];
    assign pop       = (state == S_IDLE) & ~fifo_empty;
    assign ovf_set   = push & fifo_full & ~pop;
    assign baud_done = (baud == BAUD_LAST);
    assign irq       = fifo_empty & (state == S_IDLE);
    assign unused    = ^{addr[1:0], writedata[31:8], fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (writedata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow flag; a drop in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (!reset)
            overflow <= 1'b0;
        else if (ovf_set)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Datapath: shift register, baud counter and bit index
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift   <= '0;
            baud    <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift   <= fifo_dout;
                        baud    <= '0;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud    <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: baud <= baud_done ? '0 : baud + 1'b1;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!fifo_empty) state_nxt = S_START;
            S_START: if (baud_done) state_nxt = S_DATA;
            S_DATA:  if (baud_done && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (baud_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line and busy outputs decoded from the state
    always_comb begin
        tx   = 1'b1;
        busy = (state != S_IDLE);
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift[0];
            default: tx = 1'b1;
        endcase
    end

    // Combinational register read
    always_comb begin
        rdata = '0;
        if (sel && idx == IDX_STATUS) begin
            rdata[ST_FULL_BIT]  = fifo_full;
            rdata[ST_EMPTY_BIT] = fifo_empty;
            rdata[ST_BUSY_BIT]  = busy;
            rdata[ST_OVF_BIT]   = overflow;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        MemWrite;
    logic [31:0] writedata;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .MemWrite  (MemWrite),
        .writedata (writedata),
        .sel       (sel),
        .rdata     (rdata),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model: queued bytes, current frame as a 10-bit vector and position
    byte unsigned mq[$];
    bit           m_ovf;
    bit           m_in_frame;
    logic [9:0]   m_frame;
    int           m_pos;
    bit           m_valid = 0;

    initial forever begin : model_blk
        bit m_pop, m_push, m_full, m_clr;
        byte unsigned head;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            m_ovf      = 0;
            m_in_frame = 0;
            m_pos      = 0;
            m_valid    = 1;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = !m_in_frame && mq.size() != 0;
            m_push = (addr[31:4] == BASE[31:4]) && MemWrite && addr[3:2] == 2'd0;
            m_clr  = (addr[31:4] == BASE[31:4]) && MemWrite && addr[3:2] == 2'd1 && writedata[3];
            if (m_in_frame) begin
                m_pos++;
                if (m_pos == 10 * CPB) m_in_frame = 0;
            end
            if (m_pop) begin
                head       = mq.pop_front();
                m_frame    = {1'b1, head, 1'b0};
                m_in_frame = 1;
                m_pos      = 0;
            end
            if (m_push && (!m_full || m_pop)) mq.push_back(writedata[7:0]);
            if (m_push && m_full && !m_pop) m_ovf = 1;
            else if (m_clr) m_ovf = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin : cmp_blk
        logic [31:0] exp_rd;
        logic        exp_sel;
        logic        exp_tx;
        @(negedge clk);
        if (m_valid) begin
            exp_sel = (addr[31:4] == BASE[31:4]);
            exp_tx  = m_in_frame ? m_frame[m_pos / CPB] : 1'b1;
            exp_rd  = '0;
            if (exp_sel && addr[3:2] == 2'd1)
                exp_rd = {28'd0, m_ovf, m_in_frame, mq.size() == 0, mq.size() == DEPTH};
            check("model_tx", {31'd0, tx}, {31'd0, exp_tx});
            check("model_irq", {31'd0, irq}, {31'd0, (mq.size() == 0 && !m_in_frame)});
            check("model_sel", {31'd0, sel}, {31'd0, exp_sel});
            check("model_rdata", rdata, exp_rd);
        end
    end

    // Line receiver: samples each bit mid-cell and collects decoded bytes
    byte unsigned rxq[$];
    initial forever begin : rx_blk
        logic [7:0] b;
        @(negedge clk);
        if (m_valid && tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            rxq.push_back(b);
        end
    end

    // Present a bus cycle and let one rising edge sample it
    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
        addr      = a;
        MemWrite  = we;
        writedata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(BASE + 32'h4, 1'b0, 32'h0);
    endtask

    // Combinational read without consuming an edge
    task automatic peek(input logic [31:0] a);
        addr     = a;
        MemWrite = 1'b0;
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [9:0] pat;
        reset     = 1'b0;
        addr      = BASE + 32'h4;
        MemWrite  = 1'b0;
        writedata = '0;

        // 1. Reset
        drive(BASE + 32'h4, 1'b0, 32'h0);
        drive(BASE + 32'h4, 1'b0, 32'h0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd1);
        check("rst_status", rdata, 32'h2);
        reset = 1'b1;
        peek(32'h2000_0000);
        check("out_of_window_sel", {31'd0, sel}, 32'd0);
        check("out_of_window_rdata", rdata, 32'h0);
        idle(2);

        // 2. Single byte 0x55: start, LSB-first data, stop
        drive(BASE, 1'b1, 32'h55);
        check("s2_tx_before_pop", {31'd0, tx}, 32'd1);
        check("s2_txdata_read", rdata, 32'h0);
        pat = 10'b1010101010;
        for (int j = 0; j < 40; j++) begin
            drive(BASE + 32'h4, 1'b0, 32'h0);
            check("s2_line_bit", {31'd0, tx}, {31'd0, pat[j / 4]});
        end
        idle(2);
        check("s2_irq_after", {31'd0, irq}, 32'd1);
        check("s2_status_after", rdata, 32'h2);

        // 3. Five back-to-back stores, then one that overflows
        rxq.delete();
        drive(BASE, 1'b1, 32'h41);
        drive(BASE, 1'b1, 32'h42);
        check("s3_first_popped", {31'd0, tx}, 32'd0);
        drive(BASE, 1'b1, 32'h43);
        drive(BASE, 1'b1, 32'h44);
        drive(BASE, 1'b1, 32'h45);
        peek(BASE + 32'h4);
        check("s3_status_full", rdata, 32'h5);
        drive(BASE, 1'b1, 32'h46);
        peek(BASE + 32'h4);
        check("s3_status_ovf", rdata, 32'hD);

        // 4. Clear overflow
        drive(BASE + 32'h4, 1'b1, 32'h8);
        peek(BASE + 32'h4);
        check("s4_status_cleared", rdata, 32'h5);
        idle(240);
        check("s3_rx_count", rxq.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < rxq.size())
                check("s3_rx_byte", {24'd0, rxq[i]}, 32'h41 + i);
        check("s4_status_idle", rdata, 32'h2);

        // 5. Reset during DATA bit 3 of 0xA3 with two bytes queued
        drive(BASE, 1'b1, 32'hA3);
        drive(BASE, 1'b1, 32'h11);
        drive(BASE, 1'b1, 32'h22);
        idle(16);
        check("s5_in_bit3", {31'd0, tx}, 32'd0);
        peek(BASE + 32'h4);
        check("s5_status_busy", rdata, 32'h4);
        reset = 1'b0;
        drive(BASE + 32'h4, 1'b0, 32'h0);
        check("s5_tx_after_reset", {31'd0, tx}, 32'd1);
        check("s5_status_after_reset", rdata, 32'h2);
        reset = 1'b1;
        idle(60);
        check("s5_no_more_frames", {31'd0, tx}, 32'd1);
        check("s5_status_late", rdata, 32'h2);

        // 6. Unmapped register index
        drive(BASE + 32'h8, 1'b1, 32'h99);
        peek(BASE + 32'h8);
        check("s6_idx2_read", rdata, 32'h0);
        drive(BASE + 32'hC, 1'b1, 32'h77);
        peek(BASE + 32'hC);
        check("s6_idx3_read", rdata, 32'h0);
        idle(3);
        check("s6_tx_idle", {31'd0, tx}, 32'd1);
        check("s6_status", rdata, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
